// File: rtl/winload_pkg.sv
// Shared types and default sizing for the window pixel loader.
package winload_pkg;
  localparam int PIXEL_W_DEF = 8;
  localparam int WIN_DIM_DEF = 5;
  localparam int ADDR_W_DEF  = 32;
  localparam int WIN_PIXELS  = WIN_DIM_DEF * WIN_DIM_DEF;
  localparam int PIX_IDX_W   = $clog2(WIN_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ADDR,
    S_MEM_RD,
    S_CAPTURE,
    S_FULL
  } state_e;
endpackage

// File: rtl/window_shift_buffer.sv
// Window pixel storage, written one slot at a time by index.
// WINLOAD_CHECKSUM_EN adds a running unsigned pixel sum over the window.
module window_shift_buffer
  import winload_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int NPIX    = WIN_PIXELS,
  parameter int IDX_W   = PIX_IDX_W
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [PIXEL_W-1:0]      data_i,
  output logic [NPIX*PIXEL_W-1:0] window_o
`ifdef WINLOAD_CHECKSUM_EN
  ,
  output logic [PIXEL_W+IDX_W:0]  sum_o
`endif
);
  logic [NPIX-1:0][PIXEL_W-1:0] win_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) win_q <= '0;
    else if (wr_en_i) win_q[idx_i] <= data_i;
  end

  assign window_o = win_q;

`ifdef WINLOAD_CHECKSUM_EN
  localparam int SW = PIXEL_W + IDX_W + 1;
  logic [SW-1:0] sum_q;

  // Slot 0 restarts the sum so it always covers exactly one window.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sum_q <= '0;
    else if (wr_en_i) sum_q <= (idx_i == '0) ? SW'(data_i) : sum_q + SW'(data_i);
  end

  assign sum_o = sum_q;
`endif
endmodule

// File: rtl/window_pixel_loader.sv
// Loads a WIN_DIM x WIN_DIM pixel window: address request, SRAM read, capture,
// then valid/ack delivery. WINLOAD_CHECKSUM_EN adds o_window_sum.
module window_pixel_loader
  import winload_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int WIN_DIM = WIN_DIM_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                i_enable,
  output logic                                o_inc_raddr,
  input  logic                                i_r_ready,
  input  logic [ADDR_W-1:0]                   i_raddr,
  output logic                                o_mem_read,
  output logic [ADDR_W-1:0]                   o_mem_addr,
  input  logic                                i_mem_busy,
  input  logic [PIXEL_W-1:0]                  i_mem_rdata,
  output logic [WIN_DIM*WIN_DIM*PIXEL_W-1:0]  o_window,
  output logic                                o_window_valid,
  input  logic                                i_window_ack,
  output logic [15:0]                         o_win_count
`ifdef WINLOAD_CHECKSUM_EN
  ,
  output logic [PIXEL_W+$clog2(WIN_DIM*WIN_DIM):0] o_window_sum
`endif
);
  localparam int NPIX  = WIN_DIM * WIN_DIM;
  localparam int IDX_W = $clog2(NPIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
  logic               inc_q, inc_d;
  logic               rd_q, rd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               wr_en;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      pix_idx_q <= '0;
      inc_q     <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pix_idx_q <= pix_idx_d;
      inc_q     <= inc_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pix_idx_d = pix_idx_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    case (state_q)
      S_IDLE:      if (i_enable) state_d = S_REQ;
      S_REQ:       state_d = S_WAIT_ADDR;
      S_WAIT_ADDR: if (i_r_ready) begin
        addr_d  = i_raddr;
        state_d = S_MEM_RD;
      end
      S_MEM_RD:    if (rd_q && !i_mem_busy) state_d = S_CAPTURE;
      S_CAPTURE: begin
        wr_en = 1'b1;
        if (pix_idx_q == LAST_IDX) begin
          pix_idx_d = '0;
          valid_d   = 1'b1;
          state_d   = S_FULL;
        end else begin
          pix_idx_d = pix_idx_q + 1'b1;
          state_d   = S_REQ;
        end
      end
      S_FULL:      if (i_window_ack && valid_q) begin
        valid_d = 1'b0;
        cnt_d   = cnt_q + 16'd1;
        state_d = i_enable ? S_REQ : S_IDLE;
      end
      default:     state_d = S_IDLE;
    endcase
    // Registered strobes track the state being entered.
    inc_d = (state_d == S_REQ);
    rd_d  = (state_d == S_MEM_RD);
  end

  window_shift_buffer #(
    .PIXEL_W (PIXEL_W),
    .NPIX    (NPIX),
    .IDX_W   (IDX_W)
  ) u_buf (
    .clk      (clk),
    .n_rst    (n_rst),
    .wr_en_i  (wr_en),
    .idx_i    (pix_idx_q),
    .data_i   (i_mem_rdata),
    .window_o (o_window)
`ifdef WINLOAD_CHECKSUM_EN
    ,
    .sum_o    (o_window_sum)
`endif
  );

  assign o_inc_raddr    = inc_q;
  assign o_mem_read     = rd_q;
  assign o_mem_addr     = addr_q;
  assign o_window_valid = valid_q;
  assign o_win_count    = cnt_q;
endmodule

// File: tb/tb_window_pixel_loader.sv
// Directed bench for window_pixel_loader with an address/SRAM responder and
// an expected-pixel queue filled per address request.
module tb_window_pixel_loader;
  localparam int PW = 8, WD = 5, AW = 32, NP = WD * WD;

  logic              clk, n_rst, i_enable, i_r_ready, i_mem_busy, i_window_ack;
  logic [AW-1:0]     i_raddr;
  logic [PW-1:0]     i_mem_rdata;
  logic              o_inc_raddr, o_mem_read, o_window_valid;
  logic [AW-1:0]     o_mem_addr;
  logic [NP*PW-1:0]  o_window;
  logic [15:0]       o_win_count;
`ifdef WINLOAD_CHECKSUM_EN
  logic [PW+$clog2(NP):0] o_window_sum;
`endif

  window_pixel_loader #(.PIXEL_W(PW), .WIN_DIM(WD), .ADDR_W(AW)) dut (
    .clk(clk), .n_rst(n_rst), .i_enable(i_enable), .o_inc_raddr(o_inc_raddr),
    .i_r_ready(i_r_ready), .i_raddr(i_raddr), .o_mem_read(o_mem_read),
    .o_mem_addr(o_mem_addr), .i_mem_busy(i_mem_busy), .i_mem_rdata(i_mem_rdata),
    .o_window(o_window), .o_window_valid(o_window_valid),
    .i_window_ack(i_window_ack), .o_win_count(o_win_count)
`ifdef WINLOAD_CHECKSUM_EN
    , .o_window_sum(o_window_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int cyc = 0, t_start = 0, t_valid = 0, inc_cnt = 0, last_pix = -1, req_total = 0;
  int rdy_dly [NP];
  int busy_dly[NP];
  bit fill_ff = 1'b0, spur_rdy = 1'b0;
  logic [7:0] xkey = 8'h00;
  logic [PW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix_val(input int p);
    return fill_ff ? 8'hFF : (8'(p) ^ xkey);
  endfunction

  // Responder: address counter and SRAM with per-pixel delays.
  initial begin
    bit rdy_pend, rd_active, prev_valid;
    int rdy_wait, rdy_pix, busy_left;
    logic [AW-1:0] rd_addr;
    i_r_ready = 0; i_raddr = '0; i_mem_busy = 0; i_mem_rdata = '0;
    rdy_pend = 0; rd_active = 0; prev_valid = 0;
    rdy_wait = 0; rdy_pix = 0; busy_left = 0; rd_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!n_rst) begin
        rdy_pend = 0; rd_active = 0; prev_valid = 0; req_total = 0;
        exp_q.delete();
        i_r_ready = 0; i_mem_busy = 0;
        continue;
      end
      i_r_ready = spur_rdy;
      if (spur_rdy) i_raddr = 32'hDEAD_BEEF;
      if (rdy_pend) begin
        if (rdy_wait == 0) begin
          i_r_ready = 1; i_raddr = AW'(100 + rdy_pix); rdy_pend = 0;
        end else rdy_wait--;
      end
      if (o_inc_raddr) begin
        rdy_pix = req_total % NP;
        if (rdy_pix == 0) t_start = cyc;
        rdy_pend = 1; rdy_wait = rdy_dly[rdy_pix];
        exp_q.push_back(pix_val(rdy_pix));
        req_total++; inc_cnt++; last_pix = rdy_pix;
      end
      i_mem_busy = 0;
      if (o_mem_read) begin
        if (!rd_active) begin
          rd_active = 1; rd_addr = o_mem_addr;
          busy_left = busy_dly[(int'(o_mem_addr) - 100) % NP];
        end
        if (busy_left > 0) begin
          i_mem_busy = 1; busy_left--;
          chk("busy_addr_stable", o_mem_addr, rd_addr);
        end else begin
          i_mem_rdata = pix_val(int'(o_mem_addr) - 100); rd_active = 0;
        end
      end
      if (o_window_valid && !prev_valid) t_valid = cyc;
      prev_valid = o_window_valid;
    end
  end

  task automatic wait_valid(input string tag);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk); #1;
      seen = o_window_valid;
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_pix(input int p);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (last_pix == p);
    end
    if (!seen) chk("wait_pix_timeout", 0, 1);
  endtask

  task automatic check_window(input string tag);
    logic [NP*PW-1:0] e = '0;
    chk({tag, "_qsize"}, exp_q.size(), NP);
    for (int k = 0; k < NP; k++)
      if (exp_q.size() > 0) e[k*PW +: PW] = exp_q.pop_front();
    chk(tag, o_window, e);
  endtask

  task automatic do_ack();
    @(negedge clk); i_window_ack = 1;
    @(negedge clk); i_window_ack = 0;
    #1;
  endtask

  initial begin
    logic [NP*PW-1:0] win_snap;
    int inc_snap;
    n_rst = 0; i_enable = 0; i_window_ack = 0;
    for (int k = 0; k < NP; k++) begin rdy_dly[k] = 0; busy_dly[k] = 0; end
    repeat (3) @(negedge clk);
    n_rst = 1;
    // Idle with enable low
    repeat (20) @(negedge clk);
    #1;
    chk("rst_inc", o_inc_raddr, 0);
    chk("rst_mem_read", o_mem_read, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_window", o_window, 0);
    chk("rst_valid", o_window_valid, 0);
    chk("rst_count", o_win_count, 0);
    chk("idle_no_inc", inc_cnt, 0);

    // Window 1: no stalls
    i_enable = 1;
    wait_valid("w1");
    chk("w1_latency", t_valid - t_start, 100);
    check_window("w1_data");
    chk("w1_count_pre", o_win_count, 0);
    busy_dly[7] = 3; rdy_dly[12] = 2; xkey = 8'h5A;
    do_ack();
    chk("w1_valid_clr", o_window_valid, 0);
    chk("w1_count_post", o_win_count, 1);

    // Window 2: stalls, then withheld ack with spurious ready pulses
    wait_valid("w2");
    chk("w2_latency", t_valid - t_start, 105);
    check_window("w2_data");
    win_snap = o_window; inc_snap = inc_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); spur_rdy = (i % 3 == 0);
    end
    @(negedge clk); spur_rdy = 0; #1;
    chk("hold_window", o_window, win_snap);
    chk("hold_no_inc", inc_cnt, inc_snap);
    chk("hold_valid", o_window_valid, 1);
    chk("hold_addr", o_mem_addr, 124);
    busy_dly[7] = 0; rdy_dly[12] = 0; xkey = 8'hC3;
    do_ack();
    chk("w2_count_post", o_win_count, 2);

    // Window 3: enable dropped at pixel 10
    wait_pix(10);
    i_enable = 0;
    wait_valid("w3");
    check_window("w3_data");
    do_ack();
    chk("w3_count_post", o_win_count, 3);
    inc_snap = inc_cnt;
    repeat (10) @(negedge clk);
    i_window_ack = 1;
    @(negedge clk); i_window_ack = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_after_drop", inc_cnt, inc_snap);
    chk("spur_ack_count", o_win_count, 3);
    chk("spur_ack_valid", o_window_valid, 0);

    // Reset mid-window at pixel 13
    xkey = 8'h33; i_enable = 1;
    wait_pix(13);
    repeat (2) @(negedge clk);
    n_rst = 0; #1;
    inc_snap = inc_cnt;
    chk("mrst_inc", o_inc_raddr, 0);
    chk("mrst_mem_read", o_mem_read, 0);
    chk("mrst_mem_addr", o_mem_addr, 0);
    chk("mrst_window", o_window, 0);
    chk("mrst_count", o_win_count, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("mrst_no_inc", inc_cnt, inc_snap);
    n_rst = 1;
    wait_valid("w4");
    chk("w4_latency", t_valid - t_start, 100);
    check_window("w4_data");
    fill_ff = 1;
    do_ack();
    chk("w4_count_post", o_win_count, 1);

    // Window 5: all 0xFF
    wait_valid("w5");
    check_window("w5_data");
`ifdef WINLOAD_CHECKSUM_EN
    chk("w5_sum", o_window_sum, 6375);
`endif
    i_enable = 0;
    do_ack();
    chk("w5_count_post", o_win_count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/window_pixel_loader.md
# window_pixel_loader

Pulls a 5x5 pixel window from frame SRAM one pixel at a time, as the consumer of the read-address generator. Each pixel takes one increment request to the address counter, one SRAM read at the returned address, and one capture into a window buffer. When the window is full it is presented to the edge-detection datapath under a valid/ack handshake.

## Interface
Parameters:
- PIXEL_W, 8: bits per pixel.
- WIN_DIM, 5: window edge length. The window holds WIN_DIM*WIN_DIM pixels (25 by default).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- i_enable  in  1  level; run window loading while high.
- o_inc_raddr  out  1  one-cycle pulse that asks the address counter for the next address.
- i_r_ready  in  1  one-cycle pulse; i_raddr is valid in the same cycle.
- i_raddr  in  ADDR_W  read address from the address counter.
- o_mem_read  out  1  SRAM read request.
- o_mem_addr  out  ADDR_W  SRAM address.
- i_mem_busy  in  1  SRAM stall.
- i_mem_rdata  in  PIXEL_W  SRAM read data.
- o_window  out  WIN_DIM*WIN_DIM*PIXEL_W  packed window. Pixel k occupies [k*PIXEL_W +: PIXEL_W], k=0 is top-left, row-major.
- o_window_valid  out  1  window is complete.
- i_window_ack  in  1  consumer has taken the window.
- o_win_count  out  16  number of windows delivered since reset.

## Operation
- All outputs are registered. Reset values: o_inc_raddr=0, o_mem_read=0, o_mem_addr=0, o_window=0, o_window_valid=0, o_win_count=0. Reset also sets the state to IDLE and the pixel index pix_idx to 0.
- FSM states: IDLE, REQ, WAIT_ADDR, MEM_RD, CAPTURE, FULL.
- IDLE: go to REQ when i_enable=1.
- REQ: assert o_inc_raddr for exactly one cycle, then go to WAIT_ADDR.
- WAIT_ADDR: hold until i_r_ready=1. On that cycle latch i_raddr into o_mem_addr, then go to MEM_RD. There is no timeout.
- MEM_RD: hold o_mem_read=1 and o_mem_addr stable. The read is accepted on the edge where o_mem_read=1 and i_mem_busy=0; then drop o_mem_read and go to CAPTURE.
- CAPTURE: i_mem_rdata is valid in this cycle (one-cycle read latency). Write it into slot pix_idx.
  - If pix_idx=WIN_DIM*WIN_DIM-1: set pix_idx=0, set o_window_valid=1, go to FULL.
  - Otherwise: increment pix_idx and go to REQ.
- FULL: o_window and o_window_valid are held stable until i_window_ack=1 is sampled while o_window_valid=1. On that edge:
  - clear o_window_valid;
  - increment o_win_count (wraps 65535 -> 0);
  - go to REQ if i_enable=1, else IDLE.
- pix_idx width is $clog2(WIN_DIM*WIN_DIM).
- Boundary conditions:
  - i_r_ready outside WAIT_ADDR is ignored.
  - i_window_ack outside FULL is ignored.
  - i_enable deasserted mid-window: the current window still completes and is delivered; the FSM goes to IDLE after the ack.
  - i_enable is only sampled in IDLE and at the FULL exit.
  - i_mem_busy held high indefinitely: the FSM stays in MEM_RD with o_mem_read held high.
  - Reset asserted mid-operation: everything returns to reset values immediately. The partial window is discarded. No request is issued until after reset deasserts.
- o_window is not cleared between windows. Every slot is overwritten before the next valid.

## Timing
- Per pixel, minimum 4 cycles: REQ, WAIT_ADDR (i_r_ready arriving in the same cycle), MEM_RD (not busy), CAPTURE.
- Each cycle of i_r_ready delay or i_mem_busy stall adds one cycle.
- Minimum time from REQ entry to o_window_valid rising: 100 cycles at WIN_DIM=5.
- o_window_valid rises on the edge that ends the last CAPTURE cycle.
- Earliest next o_inc_raddr: the cycle after the ack edge.
- Only one address request may be outstanding at any time.

## Configuration
- WINLOAD_CHECKSUM_EN defined:
  - Adds output o_window_sum, PIXEL_W+$clog2(WIN_DIM*WIN_DIM)+1 bits wide.
  - Accumulated incrementally in CAPTURE, unsigned, zero-extended.
  - Cleared when pix_idx=0 is captured.
  - Valid and stable while o_window_valid=1. Reset value 0.
- Not defined: the port and accumulator do not exist; all other behaviour is identical.

## Structure
- Shared package winload_pkg holds:
  - the state enum typedef;
  - the constants WIN_PIXELS (=WIN_DIM*WIN_DIM) and PIX_IDX_W;
  - the default widths.
- Sub-module window_shift_buffer: the WIN_PIXELS x PIXEL_W storage. It has a write enable and index input and a packed output, and also holds the optional checksum accumulator.
- The FSM, handshakes and o_win_count stay in window_pixel_loader.

## Test plan
- Reset and idle: n_rst low, then i_enable=0 for 20 cycles -> all outputs 0, no o_inc_raddr pulse.
- Single window, no stalls: responder returns i_raddr = 100+k with immediate ready, and memory returns rdata=k -> valid rises 100 cycles after REQ. o_window slot k = k. o_win_count goes 0 -> 1 on ack.
- Stalls: i_mem_busy held 3 cycles on pixel 7, i_r_ready delayed 2 cycles on pixel 12 -> valid delayed exactly 5 cycles, data unchanged, o_mem_addr stable throughout the busy cycles.
- Ack timing and enable drop: ack withheld 10 cycles -> o_window stable and no o_inc_raddr. i_enable dropped at pixel 10 -> window completes, FSM goes to IDLE after ack.
- Reset mid-window at pixel 13 -> outputs return to reset values. After re-enable, the first capture lands in slot 0.
- With WINLOAD_CHECKSUM_EN: all pixels 0xFF -> o_window_sum = 25*255 = 6375. Spurious i_r_ready and ack pulses in other states are ignored.
